alarm_trigger: RTL

- Downstream consumer of the alarm-time setting stage and the live timekeeping counter.
- Compares the live time against the stored alarm time and raises the buzzer on a match.
- Manages snooze, stop, ring timeout and the snooze limit with a 3-state FSM.
- Drives the buzzer and the status outputs seen by the display and LED logic.

---
 rtl/alarm_trigger.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm match, ring timeout, snooze and stop control; optional BUZZER_BEEP_EN gives a 0.5 Hz beep
module alarm_trigger #(
    parameter int SNOOZE_SECONDS = 300,
    parameter int RING_TIMEOUT   = 60,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TICK_1HZ,
    input  logic [7:0]  cur_seconds,
    input  logic [7:0]  cur_minutes,
    input  logic [7:0]  cur_hours,
    input  logic [7:0]  alm_seconds,
    input  logic [7:0]  alm_minutes,
    input  logic [7:0]  alm_hours,
    input  logic        ALARM_ENABLE,
    input  logic        SNOOZE,
    input  logic        STOP,
    output logic        BUZZER,
    output logic        RINGING,
    output logic        SNOOZING,
    output logic [15:0] snooze_left,
    output logic [1:0]  snooze_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;

    logic        match;
    logic        match_q;
    logic        snooze_q;
    logic        stop_q;
    logic        match_rise;
    logic        snooze_rise;
    logic        stop_rise;

    logic [7:0]  ring_cnt;
    logic [7:0]  ring_cnt_d;
    logic [15:0] left_q;
    logic [15:0] left_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        buzzer_q;
    logic        buzzer_d;

    logic        timeout;
    logic        snooze_ok;
    logic [8:0]  ring_cnt_inc;

    // Live time equals alarm time on all three fields
    always_comb begin
        match = (cur_seconds == alm_seconds) &&
                (cur_minutes == alm_minutes) &&
                (cur_hours   == alm_hours);
    end

    // Edge detectors; a held match or held button acts only once
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            match_q  <= 1'b0;
            snooze_q <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            match_q  <= match;
            snooze_q <= SNOOZE;
            stop_q   <= STOP;
        end
    end

    // Rising edges, ring timeout on the current tick, snooze allowance
    always_comb begin
        match_rise   = match  && !match_q;
        snooze_rise  = SNOOZE && !snooze_q;
        stop_rise    = STOP   && !stop_q;
        ring_cnt_inc = {1'b0, ring_cnt} + 9'd1;
        timeout      = TICK_1HZ && (ring_cnt_inc >= 9'(RING_TIMEOUT));
        snooze_ok    = 32'(count_q) < 32'(MAX_SNOOZES);
    end

    // Next-state and next-counter logic, highest-priority event first
    always_comb begin
        state_d    = state;
        ring_cnt_d = ring_cnt;
        left_d     = left_q;
        count_d    = count_q;

        if (!ALARM_ENABLE) begin
            state_d    = S_IDLE;
            ring_cnt_d = 8'd0;
            left_d     = 16'd0;
            count_d    = 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    ring_cnt_d = 8'd0;
                    left_d     = 16'd0;
                    count_d    = 2'd0;
                    if (match_rise) begin
                        state_d = S_RINGING;
                    end
                end

                S_RINGING: begin
                    if (stop_rise || timeout) begin
                        state_d    = S_IDLE;
                        ring_cnt_d = 8'd0;
                        left_d     = 16'd0;
                        count_d    = 2'd0;
                    end else if (snooze_rise && snooze_ok) begin
                        state_d    = S_SNOOZE;
                        ring_cnt_d = 8'd0;
                        left_d     = 16'(SNOOZE_SECONDS);
                        count_d    = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
                    end else if (TICK_1HZ && (ring_cnt != 8'hFF)) begin
                        ring_cnt_d = ring_cnt + 8'd1;
                    end
                end

                S_SNOOZE: begin
                    if (stop_rise) begin
                        state_d    = S_IDLE;
                        ring_cnt_d = 8'd0;
                        left_d     = 16'd0;
                        count_d    = 2'd0;
                    end else if (TICK_1HZ) begin
                        if (left_q == 16'd1) begin
                            state_d    = S_RINGING;
                            left_d     = 16'd0;
                            ring_cnt_d = 8'd0;
                        end else if (left_q != 16'd0) begin
                            left_d = left_q - 16'd1;
                        end
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    ring_cnt_d = 8'd0;
                    left_d     = 16'd0;
                    count_d    = 2'd0;
                end
            endcase
        end
    end

    // Buzzer drive follows the state it will be in after this edge
    always_comb begin
        buzzer_d = 1'b0;
`ifdef BUZZER_BEEP_EN
        if (state_d == S_RINGING) begin
            if (state != S_RINGING) begin
                buzzer_d = 1'b1;
            end else if (TICK_1HZ) begin
                buzzer_d = !buzzer_q;
            end else begin
                buzzer_d = buzzer_q;
            end
        end
`else
        buzzer_d = (state_d == S_RINGING);
`endif
    end

    // State and counter registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            ring_cnt <= 8'd0;
            left_q   <= 16'd0;
            count_q  <= 2'd0;
            buzzer_q <= 1'b0;
        end else begin
            state    <= state_d;
            ring_cnt <= ring_cnt_d;
            left_q   <= left_d;
            count_q  <= count_d;
            buzzer_q <= buzzer_d;
        end
    end

    // Status outputs come straight from registers
    always_comb begin
        BUZZER       = buzzer_q;
        RINGING      = (state == S_RINGING);
        SNOOZING     = (state == S_SNOOZE);
        snooze_left  = left_q;
        snooze_count = count_q;
    end

endmodule
